// File: rtl/trip_timer.sv
// rtl/trip_timer.sv - half-second/second strobes and packed h:m:s trip time
// Optional load port compiled in with TRIP_TIMER_LOAD_EN.
module trip_timer #(
   parameter int HALF_SEC_CYCLES = 1000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        clear,
`ifdef TRIP_TIMER_LOAD_EN
   input  logic        load,
   input  logic [18:0] load_value,
`endif
   output logic        half_sec_pulse,
   output logic        sec_pulse,
   output logic [18:0] HMS_time,
   output logic        overflow
);

   localparam logic [15:0] LAST_COUNT = 16'(HALF_SEC_CYCLES - 1);

   logic [15:0] prescaler;
   logic        phase;
   logic        wrap;
   logic        sec_edge;
   logic [6:0]  hours;
   logic [5:0]  minutes;
   logic [5:0]  seconds;

   assign wrap     = (prescaler == LAST_COUNT);
   assign sec_edge = wrap && phase;
   assign HMS_time = {hours, minutes, seconds};

`ifdef TRIP_TIMER_LOAD_EN
   logic [6:0] load_hours;
   logic [5:0] load_minutes;
   logic [5:0] load_seconds;

   // Out-of-range load fields clamp to their maximum rather than wrap.
   always_comb begin
      load_hours   = (load_value[18:12] > 7'd99) ? 7'd99 : load_value[18:12];
      load_minutes = (load_value[11:6]  > 6'd59) ? 6'd59 : load_value[11:6];
      load_seconds = (load_value[5:0]   > 6'd59) ? 6'd59 : load_value[5:0];
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prescaler      <= 16'd0;
         phase          <= 1'b0;
         half_sec_pulse <= 1'b0;
         sec_pulse      <= 1'b0;
      end else begin
         half_sec_pulse <= wrap;
         sec_pulse      <= sec_edge;
         if (wrap) begin
            prescaler <= 16'd0;
            phase     <= ~phase;
         end else begin
            prescaler <= prescaler + 16'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hours    <= 7'd0;
         minutes  <= 6'd0;
         seconds  <= 6'd0;
         overflow <= 1'b0;
      end else if (clear) begin
         hours    <= 7'd0;
         minutes  <= 6'd0;
         seconds  <= 6'd0;
         overflow <= 1'b0;
`ifdef TRIP_TIMER_LOAD_EN
      end else if (load) begin
         hours   <= load_hours;
         minutes <= load_minutes;
         seconds <= load_seconds;
`endif
      end else if (sec_edge && run) begin
         if (seconds != 6'd59) begin
            seconds <= seconds + 6'd1;
         end else begin
            seconds <= 6'd0;
            if (minutes != 6'd59) begin
               minutes <= minutes + 6'd1;
            end else begin
               minutes <= 6'd0;
               if (hours != 7'd99) begin
                  hours <= hours + 7'd1;
               end else begin
                  hours    <= 7'd0;
                  overflow <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: doc/trip_timer.md
# trip_timer

Trip timekeeper for the bike computer. Derives the half-second and one-second strobes from the system clock and keeps the elapsed riding time as packed hours/minutes/seconds. It is the source of `half_sec_pulse`, `sec_pulse` and `HMS_time`, which the display `control` block consumes for blinking, mode timing and the TIM readout.

## Interface
Parameters:
- `HALF_SEC_CYCLES`, default 1000: clock cycles per half second (25 in simulation benches). Legal range 2..65535.

Ports:
- `clock`  in  1: system clock, rising-edge active.
- `reset`  in  1: asynchronous, active-high reset.
- `run`  in  1: when high, time advances on each second strobe. When low, time is frozen and strobes keep running.
- `clear`  in  1: synchronous; zeroes time and overflow.
- `half_sec_pulse`  out  1: one-cycle strobe every `HALF_SEC_CYCLES` cycles.
- `sec_pulse`  out  1: one-cycle strobe on every second `half_sec_pulse`.
- `HMS_time`  out  19: packed time. Hours [18:12] (0..99), minutes [11:6] (0..59), seconds [5:0] (0..59).
- `overflow`  out  1: sticky flag, set when time wraps past 99:59:59.
- `load`, `load_value[18:0]`  in: present only with `TRIP_TIMER_LOAD_EN` (see Configuration).

## Operation
- The prescaler counter, 16 bits, is free-running from 0 to `HALF_SEC_CYCLES`-1 and then wraps to 0.
  - It is not affected by `run` or `clear`.
- A phase bit toggles on every prescaler wrap.
- Strobe generation happens on the edge where the prescaler wraps:
  - `half_sec_pulse` is registered high for one cycle.
  - If the phase bit was 1 before the toggle, `sec_pulse` is also registered high on the same edge.
- Time update on that same `sec_pulse` edge, when `run`=1:
  - Seconds increments.
  - When seconds is 59, it goes to 0 and minutes increments.
  - When minutes is 59, it goes to 0 and hours increments.
  - When hours is 99, it goes to 0 and `overflow` is set to 1.
- Priority per edge: `clear` > `load` (if compiled) > increment.
  - `clear` zeroes all three fields and `overflow`, even on a second edge.
- `overflow` stays set until `clear` or `reset`. A further wrap keeps it at 1.
- Field arithmetic is in native width, with no BCD. Fields never exceed their maximums, so no out-of-range values are ever output.

## Timing
- Reset values: `HMS_time`=0, `overflow`=0, `half_sec_pulse`=0, `sec_pulse`=0, prescaler=0, phase=0.
- After `reset` falls, the first `half_sec_pulse` is high during cycle `HALF_SEC_CYCLES`. This is the cycle following the `HALF_SEC_CYCLES`-th rising edge.
- The first `sec_pulse` comes at 2×`HALF_SEC_CYCLES`. Thereafter `sec_pulse` has a period of exactly 2×`HALF_SEC_CYCLES` cycles.
- `sec_pulse` always coincides with a `half_sec_pulse`. Both are exactly one cycle wide.
- `HMS_time` changes on the same edge that raises `sec_pulse`, so consumers see the new time in the strobe cycle.
- `run` is sampled on the wrap edge only. A `run` toggle between strobes has no effect until the next second.
- `clear` takes effect on the next edge: zero latency in the following cycle.
- When `reset` is asserted mid-count, all state returns immediately to the reset values. There is no partial strobe.

## Configuration
- `TRIP_TIMER_LOAD_EN` defined:
  - Adds the `load` and `load_value[18:0]` inputs.
  - When `load`=1 (and `clear`=0), `HMS_time` takes `load_value` on the next edge, overriding any increment in that cycle. `overflow` is unchanged.
  - Out-of-range fields are saturated: hours >99 becomes 99, minutes >59 becomes 59, seconds >59 becomes 59.
- `TRIP_TIMER_LOAD_EN` undefined:
  - The ports are absent. Time can only be changed by increment, `clear` or `reset`.

## Test plan
With `HALF_SEC_CYCLES`=25:
- Release `reset` with `run`=1: `half_sec_pulse` is high in cycles 25, 50 and 75, and `sec_pulse` is high only in cycle 50. `HMS_time` becomes 0:00:01 at cycle 50.
- Hold `run`=1 for 3600 seconds: `HMS_time` is 1:00:00, with minutes/seconds rolling 59→0 exactly at the hour. `overflow`=0.
- Load (or run to) 99:59:59 and apply one `sec_pulse`: `HMS_time`=0, `overflow`=1. Then pulse `clear`: `overflow`=0.
- Drop `run` for 5 seconds: `HMS_time` holds while `sec_pulse` continues every 50 cycles. Raise `run`: counting resumes from the held value.
- Assert `clear` in the same cycle a `sec_pulse` edge occurs at 0:10:07: the result is 0:00:00, with no increment.
- `TRIP_TIMER_LOAD_EN`: load `{7'd120, 6'd61, 6'd5}` → `HMS_time` = 99:59:05.
- `TRIP_TIMER_LOAD_EN`: assert `load` with `clear` in the same cycle → 0.
